// File: rtl/filter_line_feeder.sv
// filter_line_feeder: upstream sequencer for the 3x3 line-buffer filter.
// Buffers an RGB565 raster stream in a small FIFO, writes each pixel into the
// filter at the current column cursor, waits for the filtered result and
// re-emits it downstream with start-of-frame / end-of-line markers.
// Optional build macro: FEEDER_BORDER_ZERO_EN zeroes the output pixel on the
// frame border, where the filter has no valid 3x3 neighbourhood.
module filter_line_feeder #(
  parameter int BLOCK_LENGTH = 720,
  parameter int LINES        = 480,
  parameter int FIFO_DEPTH   = 16,
  parameter int MIN_WAIT     = 3,
  parameter int RDY_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] s_data,
  input  logic        s_sof,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] f_d_in,
  output logic        f_wren,
  output logic [9:0]  f_cursor,
  input  logic        f_d_rdy,
  input  logic [15:0] f_d_out,
  output logic [15:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic        err_timeout
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ROW_W  = $clog2(LINES);
  localparam int WAIT_W = $clog2(RDY_TIMEOUT + 1);

  localparam logic [9:0]        COL_LAST     = 10'(BLOCK_LENGTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST     = ROW_W'(LINES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MIN     = WAIT_W'(MIN_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_TIMEOUT = WAIT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  FIFO_FULL    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // FIFO storage: each entry is {sof, data}
  logic [16:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic [16:0]       head;
  logic              push;
  logic              pop;

  // Raster position and per-pixel sequencing state
  logic [9:0]        col;
  logic [ROW_W-1:0]  row;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0]       data_q;
  logic              resync;
  logic              take_result;
  logic              timeout_hit;
  logic              beat_done;

  assign fifo_empty = (fifo_cnt == '0);
  assign s_ready    = (fifo_cnt != FIFO_FULL);
  assign push       = s_valid && s_ready;
  assign head       = fifo_mem[rd_ptr];

  // FIFO payload write; storage needs no reset since the count guards reads
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {s_sof, s_data};
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and per-cycle control strobes
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    resync      = 1'b0;
    take_result = 1'b0;
    timeout_hit = 1'b0;
    beat_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_WRITE;
          resync    = head[16] && ((col != '0) || (row != '0));
        end
      end
      ST_WRITE: begin
        pop       = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if ((wait_cnt >= WAIT_MIN) && f_d_rdy) begin
          take_result = 1'b1;
          state_nxt   = ST_OUT;
        end else if (wait_cnt == WAIT_TIMEOUT) begin
          take_result = 1'b1;
          timeout_hit = 1'b1;
          state_nxt   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          beat_done = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Column/row tracking: resync on an early start-of-frame, advance on each accepted beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (resync) begin
      col <= '0;
      row <= '0;
    end else if (beat_done) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // WAIT cycle counter, cleared while writing the pixel into the filter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == ST_WRITE) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Capture the filter result, held stable through the output handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (take_result) begin
      data_q <= f_d_out;
    end
  end

  // Sticky timeout flag; only reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_timeout <= 1'b0;
    end else if (timeout_hit) begin
      err_timeout <= 1'b1;
    end
  end

  assign f_wren   = (state == ST_WRITE);
  assign f_d_in   = f_wren ? head[15:0] : 16'h0000;
  assign f_cursor = col;
  assign m_valid  = (state == ST_OUT);
  assign m_sof    = m_valid && (col == '0) && (row == '0);
  assign m_eol    = m_valid && (col == COL_LAST);
  assign busy     = (state != ST_IDLE) || !fifo_empty;

`ifdef FEEDER_BORDER_ZERO_EN
  logic on_border;
  assign on_border = (col == '0) || (col == COL_LAST) || (row == '0) || (row == ROW_LAST);
  assign m_data    = (m_valid && on_border) ? 16'h0000 : data_q;
`else
  assign m_data    = data_q;
`endif

endmodule

// File: tb/tb_filter_line_feeder.sv
// tb_filter_line_feeder: scoreboard bench for filter_line_feeder.
// A simple filter model returns f_d_in ^ KEY; expected filter writes and
// output beats are queued at push time and checked by independent monitors.
module tb_filter_line_feeder;

  localparam int BLOCK_LENGTH = 720;
  localparam int LINES        = 480;
  localparam logic [15:0] KEY = 16'hEA34;
  localparam int PUSH_LIMIT   = 400;

  logic        clk;
  logic        reset;
  logic [15:0] s_data;
  logic        s_sof;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] f_d_in;
  logic        f_wren;
  logic [9:0]  f_cursor;
  logic        f_d_rdy;
  logic [15:0] f_d_out;
  logic [15:0] m_data;
  logic        m_sof;
  logic        m_eol;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        err_timeout;

  int vectors = 0;
  int miscompares = 0;

  logic [17:0] out_q[$];
  logic [25:0] wr_q[$];
  int mcol = 0;
  int mrow = 0;
  bit hold_ready = 0;
  bit rnd_ready = 0;
  bit prev_wren = 0;

  filter_line_feeder dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .f_d_in      (f_d_in),
    .f_wren      (f_wren),
    .f_cursor    (f_cursor),
    .f_d_rdy     (f_d_rdy),
    .f_d_out     (f_d_out),
    .m_data      (m_data),
    .m_sof       (m_sof),
    .m_eol       (m_eol),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global safety net so the run always ends
  initial begin
    #900000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expectation model: line counting, resync on sof, border zeroing
  task automatic modelPush(input logic [15:0] d, input logic sof);
    logic [15:0] ed;
    logic        esof;
    logic        eeol;
    if (sof && (mcol != 0 || mrow != 0)) begin
      mcol = 0;
      mrow = 0;
    end
    ed   = d ^ KEY;
`ifdef FEEDER_BORDER_ZERO_EN
    if (mcol == 0 || mcol == BLOCK_LENGTH - 1 || mrow == 0 || mrow == LINES - 1) ed = 16'h0000;
`endif
    esof = (mcol == 0 && mrow == 0);
    eeol = (mcol == BLOCK_LENGTH - 1);
    wr_q.push_back({10'(mcol), d});
    out_q.push_back({ed, esof, eeol});
    if (mcol == BLOCK_LENGTH - 1) begin
      mcol = 0;
      mrow = (mrow == LINES - 1) ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic sof);
    int waited;
    bit accepted;
    waited = 0;
    accepted = 0;
    @(posedge clk);
    #1;
    s_data  = d;
    s_sof   = sof;
    s_valid = 1'b1;
    while (!accepted && waited < PUSH_LIMIT) begin
      @(negedge clk);
      if (s_ready) accepted = 1;
      @(posedge clk);
      waited++;
    end
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    if (accepted) begin
      modelPush(d, sof);
    end else begin
      checkOutput("push_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (!(busy == 1'b0 && out_q.size() == 0 && m_valid == 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) checkOutput("drain_timeout", 32'(out_q.size()), 32'd0);
  endtask

  // m_ready driver: stalled, random, or always ready
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready) m_ready = 1'b0;
      else if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
      else m_ready = 1'b1;
    end
  end

  // Filter model: result available from the write onward
  initial begin
    f_d_out = 16'h0000;
    forever begin
      @(negedge clk);
      if (f_wren) f_d_out = f_d_in ^ KEY;
    end
  end

  // Filter-write monitor
  initial begin
    logic [25:0] e;
    forever begin
      @(negedge clk);
      if (f_wren) begin
        checkOutput("wren_gap", 32'(prev_wren), 32'd0);
        if (wr_q.size() == 0) begin
          checkOutput("wr_unexpected", 32'(f_cursor), 32'hFFFF);
        end else begin
          e = wr_q.pop_front();
          checkOutput("f_cursor", 32'(f_cursor), 32'(e[25:16]));
          checkOutput("f_d_in", 32'(f_d_in), 32'(e[15:0]));
        end
      end
      prev_wren = f_wren;
    end
  end

  // Output-beat monitor
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (out_q.size() == 0) begin
          checkOutput("out_unexpected", 32'(m_data), 32'hFFFF0000);
        end else begin
          e = out_q.pop_front();
          checkOutput("m_data", 32'(m_data), 32'(e[17:2]));
          checkOutput("m_sof", 32'(m_sof), 32'(e[1]));
          checkOutput("m_eol", 32'(m_eol), 32'(e[0]));
        end
      end
    end
  end

  // Directed sequence
  initial begin
    int edges;
    bit seen;
    int guard;
    s_data  = 16'h0000;
    s_sof   = 1'b0;
    s_valid = 1'b0;
    f_d_rdy = 1'b1;
    reset   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    $display("[TB] reset and idle");
    @(negedge clk);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_f_wren", 32'(f_wren), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    checkOutput("rst_cursor", 32'(f_cursor), 32'd0);

    $display("[TB] single pixel latency");
    applyStimulus(16'hF800, 1'b1);
    edges = 0;
    seen = 0;
    while (!seen && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    checkOutput("latency", 32'(edges), 32'd5);
`ifdef FEEDER_BORDER_ZERO_EN
    checkOutput("lat_data", 32'(m_data), 32'h0000);
`else
    checkOutput("lat_data", 32'(m_data), 32'h1234);
`endif
    checkOutput("lat_sof", 32'(m_sof), 32'd1);
    waitIdle(100);

    $display("[TB] full line with random stalls");
    rnd_ready = 1;
    for (int i = 0; i < BLOCK_LENGTH; i++) applyStimulus(16'(i * 37 + 5), (i == 0));
    applyStimulus(16'hBEEF, 1'b0);
    waitIdle(3000);
    rnd_ready = 0;

    $display("[TB] FIFO full");
    hold_ready = 1;
    for (int i = 0; i < 17; i++) applyStimulus(16'h4000 + 16'(i), 1'b0);
    @(negedge clk);
    checkOutput("s_ready_full", 32'(s_ready), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("s_ready_hold", 32'(s_ready), 32'd0);
    checkOutput("busy_full", 32'(busy), 32'd1);
    hold_ready = 0;
    for (int i = 17; i < 20; i++) applyStimulus(16'h4000 + 16'(i), 1'b0);
    waitIdle(500);

    $display("[TB] timeout and resync");
    f_d_rdy = 1'b0;
    applyStimulus(16'h0F0F, 1'b0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!f_wren && guard < 10);
    edges = 0;
    seen = 0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    checkOutput("timeout_edges", 32'(edges), 32'd16);
    checkOutput("err_set", 32'(err_timeout), 32'd1);
    waitIdle(100);
    f_d_rdy = 1'b1;
    applyStimulus(16'h00FF, 1'b0);
    waitIdle(100);
    checkOutput("err_sticky", 32'(err_timeout), 32'd1);
    guard = 0;
    while (mcol != 37 && guard < BLOCK_LENGTH) begin
      applyStimulus(16'h1111 + 16'(mcol), 1'b0);
      guard++;
    end
    applyStimulus(16'hC0DE, 1'b1);
    applyStimulus(16'hC0DF, 1'b0);
    waitIdle(200);

    $display("[TB] reset mid-pixel");
    f_d_rdy = 1'b0;
    applyStimulus(16'hDEAD, 1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    out_q.delete();
    wr_q.delete();
    mcol = 0;
    mrow = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    f_d_rdy = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_err", 32'(err_timeout), 32'd0);
    checkOutput("abort_s_ready", 32'(s_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    checkOutput("abort_no_beat", 32'(seen), 32'd0);

    checkOutput("out_q_left", 32'(out_q.size()), 32'd0);
    checkOutput("wr_q_left", 32'(wr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/filter_line_feeder.md
Name: filter_line_feeder

Overview:
Upstream stage for the 3x3 line-buffer filter. It accepts a raster stream of RGB565 pixels over a valid/ready handshake and buffers them in a small FIFO. It sequences each pixel into the filter's write/cursor interface, waits for the filter's data-ready, and re-emits the filtered pixel downstream with start-of-frame and end-of-line markers. It owns column/row counting so the filter only sees a cursor in 0..BLOCK_LENGTH-1.

Parameters:
BLOCK_LENGTH, 720, pixels per line; cursor wraps after BLOCK_LENGTH-1
LINES, 480, lines per frame; row wraps after LINES-1
FIFO_DEPTH, 16, input FIFO entries (power of 2)
MIN_WAIT, 3, WAIT cycles before f_d_rdy is honoured (filter RAM read latency)
RDY_TIMEOUT, 15, WAIT cycles after which the result is taken regardless of f_d_rdy

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
s_data  in  16  input pixel, RGB565
s_sof  in  1  marks the first pixel of a frame; qualified by s_valid
s_valid  in  1  input beat valid
s_ready  out  1  FIFO not full
f_d_in  out  16  pixel to filter
f_wren  out  1  filter write strobe
f_cursor  out  10  filter column cursor
f_d_rdy  in  1  filter result ready
f_d_out  in  16  filter result
m_data  out  16  filtered pixel
m_sof  out  1  first pixel of frame (col 0, row 0)
m_eol  out  1  last pixel of line (col BLOCK_LENGTH-1)
m_valid  out  1  output beat valid
m_ready  in  1  downstream accepts
busy  out  1  FSM not in IDLE, or FIFO non-empty
err_timeout  out  1  sticky; set when a timeout occurs

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, state IDLE, col=0, row=0. All outputs 0 except s_ready=1.
- Input FIFO:
  - 17 bits wide {sof, data}. A push occurs when s_valid&s_ready.
  - s_ready=0 when the FIFO holds FIFO_DEPTH entries; push is never accepted when full.
  - A push and a pop in the same cycle are both legal.
  - No bypass path: a pixel is visible to the FSM the cycle after it is pushed.
- FSM IDLE:
  - If FIFO non-empty, go to WRITE.
  - If the head entry has sof=1 and (col!=0 or row!=0), resync col=row=0 in the same edge.
- FSM WRITE (exactly 1 cycle):
  - f_wren=1, f_d_in=head data, f_cursor=col.
  - Pop the FIFO; go to WAIT with wait_cnt=0.
- FSM WAIT:
  - f_wren=0; f_cursor holds col; wait_cnt increments each cycle.
  - If wait_cnt>=MIN_WAIT-1 and f_d_rdy=1: latch m_data=f_d_out and go to OUT.
  - Else if wait_cnt==RDY_TIMEOUT-1: latch f_d_out, set err_timeout, go to OUT.
- FSM OUT:
  - m_valid=1; m_data, m_sof (col==0&&row==0) and m_eol (col==BLOCK_LENGTH-1) stay stable until m_ready.
  - On m_valid&m_ready: advance col. At BLOCK_LENGTH-1, col wraps to 0 and row increments; at LINES-1, row wraps to 0. Return to IDLE.
- Minimum latency (idle, empty FIFO, f_d_rdy=1): m_valid rises after the 5th rising edge following the accepting s handshake edge. Throughput is at most one pixel per 2+MIN_WAIT+1 cycles.
- f_cursor is always <BLOCK_LENGTH. f_wren is never high for two consecutive cycles.
- err_timeout clears only on reset.
- Asynchronous reset mid-pixel aborts it: no m_valid beat is produced for a pixel in flight.

Optional Feature:
Macro FEEDER_BORDER_ZERO_EN.
- Defined: at OUT, m_data is forced to 16'h0000 when col==0, col==BLOCK_LENGTH-1, row==0 or row==LINES-1. The filter has no valid neighbourhood at these positions. Filter sequencing is unchanged.
- Undefined: m_data is always the latched f_d_out.

Test Plan:
1. Reset then idle: reset=0 for 3 cycles, then release -> s_ready=1; m_valid, f_wren, busy, err_timeout=0; f_cursor=0.
2. Single pixel: push 16'hF800 with s_sof=1; filter model returns 16'h1234 with f_d_rdy=1 -> one f_wren pulse with f_cursor=0 and f_d_in=16'hF800; m_valid rises 5 edges after the accepting edge with m_data=16'h1234, m_sof=1, m_eol=0.
3. Full line with random m_ready stalls: push 720 pixels -> f_cursor goes 0..719 then 0; m_eol=1 only on beat 720; row=1 afterward; output beats match order.
4. FIFO full: hold m_ready=0 and push 20 pixels -> s_ready=0 after 16 FIFO entries (17 accepted including the one in flight); no beat lost or duplicated after release.
5. Timeout and resync: f_d_rdy held 0 -> result taken after 15 WAIT cycles and err_timeout=1 sticky. Then inject s_sof=1 at col 37 -> next f_cursor=0 and m_sof=1.
6. With FEEDER_BORDER_ZERO_EN: pixels at col 0 and col 719 -> m_data=0; col 5 of row 1 -> m_data=f_d_out.
